// File: rtl/vga_fetch_pkg.sv
// Shared types and defaults for the VGA line-cache fetch controller.
// Holds the fetch FSM state type, the video timing defaults and the port widths.
package vga_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DONE
  } fetch_state_t;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_TOTAL   = 525;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_ADDR_W    = 25;

  localparam int LB_ADDR_W = 11;
  localparam int COORD_W   = 10;
  localparam int PIX_W     = 8;

  function automatic int bursts_per_line(input int h_active, input int burst_len);
    return h_active / burst_len;
  endfunction

endpackage

// File: rtl/line_fetch_trigger.sv
// Edge detection on the VGA column: one pulse on entry to horizontal blanking,
// one pulse at line start, plus the line number that the next fetch targets.
module line_fetch_trigger
  import vga_fetch_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               fetch_pulse,
  output logic               line0_pulse,
  output logic [COORD_W-1:0] next_line
);

  localparam logic [COORD_W-1:0] X_TRIG = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

  logic [COORD_W-1:0] x_prev;

  // NOTE: registers are assigned with <= so each one samples pre-edge values,
  // independent of statement order inside or across always_ff blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev <= '0;
    end else begin
      x_prev <= x;
    end
  end

  assign fetch_pulse = (x == X_TRIG) && (x_prev != X_TRIG);
  assign line0_pulse = (x == '0) && (x_prev != '0);

  // The last line of the frame (inside vertical blanking) prefetches line 0.
  assign next_line = (y == Y_LAST) ? '0 : y + COORD_W'(1);

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Fetches line y+1 from the SDRAM frame buffer in bursts during horizontal
// blanking and writes it into the idle half of a ping-pong line cache.
module vga_line_fetch_ctrl
  import vga_fetch_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FRAME_BASE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  output logic                 rd_req,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic                 rd_gnt,
  input  logic                 rd_valid,
  input  logic [PIX_W-1:0]     rd_data,
  output logic                 lb_wr_en,
  output logic [LB_ADDR_W-1:0] lb_wr_addr,
  output logic [PIX_W-1:0]     lb_wr_data,
  output logic                 disp_bank,
  output logic                 underrun
);

  localparam int N_BURSTS = bursts_per_line(H_ACTIVE, BURST_LEN);
  localparam int BURST_W  = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;
  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(N_BURSTS - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic               fetch_pulse;
  logic               line0_pulse;
  logic [COORD_W-1:0] next_line;
  logic [COORD_W-1:0] line_q;
  logic [BURST_W-1:0] burst_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               fill_bank;
  logic               ready_bank;
  logic               start_fetch;
  logic               beat_take;
  logic               beat_last;
  logic [COORD_W-1:0] col;

  line_fetch_trigger #(
    .H_ACTIVE (H_ACTIVE),
    .V_TOTAL  (V_TOTAL)
  ) u_trigger (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .fetch_pulse (fetch_pulse),
    .line0_pulse (line0_pulse),
    .next_line   (next_line)
  );

  assign start_fetch = fetch_pulse && enable && (state == IDLE)
                       && (next_line < COORD_W'(V_ACTIVE));
  assign beat_take   = (state == DATA) && rd_valid;
  assign beat_last   = beat_take && (beat_q == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every variable gets a default before the case, so no path through
  // the logic leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_fetch) state_nxt = REQ;
      end
      REQ: begin
        rd_req = 1'b1;
        if (rd_gnt) state_nxt = DATA;
      end
      DATA: begin
        if (beat_last) state_nxt = (burst_q == LAST_BURST) ? DONE : REQ;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else if (start_fetch) begin
      line_q  <= next_line;
      burst_q <= '0;
      beat_q  <= '0;
    end else if (beat_take) begin
      if (beat_q == LAST_BEAT) begin
        beat_q <= '0;
        if (burst_q != LAST_BURST) burst_q <= burst_q + BURST_W'(1);
      end else begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  // Derived from registered line/burst only, so it holds steady for the whole request.
  assign rd_addr = ADDR_W'(FRAME_BASE)
                 + ADDR_W'(line_q) * ADDR_W'(H_ACTIVE)
                 + ADDR_W'(burst_q) * ADDR_W'(BURST_LEN);

  assign col = COORD_W'(burst_q) * COORD_W'(BURST_LEN) + COORD_W'(beat_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      lb_wr_en   <= 1'b0;
      lb_wr_addr <= '0;
      lb_wr_data <= '0;
    end else begin
      lb_wr_en <= beat_take;
      if (beat_take) begin
        lb_wr_addr <= {fill_bank, col};
        lb_wr_data <= rd_data;
      end
    end
  end

  // A trigger that finds the FSM busy means the previous line missed its slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_bank  <= 1'b1;
      ready_bank <= 1'b0;
      disp_bank  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (state == DONE) begin
        ready_bank <= fill_bank;
        fill_bank  <= ~fill_bank;
      end
      if (line0_pulse) disp_bank <= ready_bank;
      if (fetch_pulse && (state != IDLE)) underrun <= 1'b1;
    end
  end

endmodule
